// File: rtl/interfpga_link.sv
// interfpga_link: serialises words onto a narrow lane bus with even parity and
// receives the same framing into a FIFO with sticky error flags.
module interfpga_link #(
    parameter int DATA_W = 8,
    parameter int LANE_W = 4,
    parameter int HOLD   = 2,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [LANE_W-1:0]      data_o,
    output logic                   ctrl_o,
    output logic                   par_o,
    input  logic [LANE_W-1:0]      data_i,
    input  logic                   ctrl_i,
    input  logic                   par_i,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] rx_count,
    input  logic                   clear_err,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overflow
);

    localparam int BEATS = DATA_W / LANE_W;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int HW    = $clog2(HOLD + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [HW-1:0] LAST_SUB  = HW'(HOLD - 1);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_SEND = 2'd1;
    localparam logic [1:0] TX_GAP  = 2'd2;

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_RECV = 2'd1;
    localparam logic [1:0] RX_WAIT = 2'd2;

    if (DATA_W % LANE_W != 0 || HOLD < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("interfpga_link: invalid parameter combination");
    end

    logic [1:0]        tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              tx_par_q, tx_par_d;
    logic [BW-1:0]     tx_beat_q, tx_beat_d;
    logic [HW-1:0]     tx_sub_q, tx_sub_d;
    logic              tx_send;

    // The word is shifted down one lane per beat so the current beat is always the low lanes.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_beat_d  = tx_beat_q;
        tx_sub_d   = tx_sub_q;
        case (tx_state_q)
            TX_IDLE: if (s_valid) begin
                tx_state_d = TX_SEND;
                tx_sh_d    = s_data;
                tx_par_d   = ^s_data;
                tx_beat_d  = '0;
                tx_sub_d   = '0;
            end
            TX_SEND: if (tx_sub_q == LAST_SUB) begin
                tx_sub_d  = '0;
                tx_beat_d = tx_beat_q + BW'(1);
                tx_sh_d   = tx_sh_q >> LANE_W;
                if (tx_beat_q == LAST_BEAT) tx_state_d = TX_GAP;
            end else begin
                tx_sub_d = tx_sub_q + HW'(1);
            end
            TX_GAP:  tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_beat_q  <= '0;
            tx_sub_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_beat_q  <= tx_beat_d;
            tx_sub_q   <= tx_sub_d;
        end
    end

    assign tx_send = (tx_state_q == TX_SEND) && !reset;
    assign s_ready = (tx_state_q == TX_IDLE) && !reset;
    assign ctrl_o  = tx_send;
    assign data_o  = tx_send ? tx_sh_q[LANE_W-1:0] : '0;
    assign par_o   = tx_send & tx_par_q;

    logic [1:0]        rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    logic [BW-1:0]     rx_beat_q, rx_beat_d;
    logic [HW-1:0]     rx_sub_q, rx_sub_d;
    logic              rx_act, rx_abort, rx_sample, rx_last, rx_match;
    logic              push, wr, pop, full;

    // An IDLE cycle with ctrl_i high already counts as beat 0, sub-cycle 0.
    always_comb begin
        rx_act    = ctrl_i && (rx_state_q == RX_IDLE || rx_state_q == RX_RECV);
        rx_abort  = !ctrl_i && rx_state_q == RX_RECV;
        rx_sample = rx_act && rx_sub_q == LAST_SUB;
        rx_last   = rx_sample && rx_beat_q == LAST_BEAT;
        rx_word_d = rx_sample ? (rx_word_q >> LANE_W) | (DATA_W'(data_i) << (DATA_W - LANE_W)) : rx_word_q;
        rx_match  = (^rx_word_d) == par_i;
        rx_sub_d  = (!rx_act || rx_sample) ? '0 : rx_sub_q + HW'(1);
        rx_beat_d = !rx_act ? '0 : rx_sample ? rx_beat_q + BW'(1) : rx_beat_q;
        rx_state_d = rx_last ? RX_WAIT :
                     rx_abort ? RX_IDLE :
                     rx_act ? RX_RECV :
                     (rx_state_q == RX_WAIT && ctrl_i) ? RX_WAIT : RX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_word_q  <= '0;
            rx_beat_q  <= '0;
            rx_sub_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_word_q  <= rx_word_d;
            rx_beat_q  <= rx_beat_d;
            rx_sub_q   <= rx_sub_d;
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              perr_q, ferr_q, ovf_q;

    // Writing at the final frame edge makes the word visible the cycle after the frame.
    assign push    = rx_last && rx_match;
    assign full    = count_q == CW'(DEPTH);
    assign m_valid = (count_q != '0) && !reset;
    assign pop     = m_valid && m_ready;
    assign wr      = push && (!full || pop);
    assign count_d = count_q + CW'(wr) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr && !reset) mem_q[wr_ptr_q] <= rx_word_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(wr);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            perr_q   <= (perr_q & ~clear_err) | (rx_last & ~rx_match);
            ferr_q   <= (ferr_q & ~clear_err) | rx_abort;
            ovf_q    <= (ovf_q & ~clear_err) | (push & full & ~pop);
        end
    end

    assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    assign rx_count   = reset ? '0 : count_q;
    assign parity_err = perr_q & ~reset;
    assign frame_err  = ferr_q & ~reset;
    assign overflow   = ovf_q & ~reset;

endmodule

// File: tb/tb_interfpga_link.sv
// tb_interfpga_link: loopback bench for interfpga_link with a default-width
// instance and a 16-bit / HOLD=3 instance.
module tb_interfpga_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       clear_err, kill, flip;
    logic [7:0] a_s_data, a_m_data;
    logic       a_s_valid, a_s_ready, a_ctrl_o, a_par_o, a_ctrl_i, a_par_i;
    logic [3:0] a_data_o, a_data_i;
    logic       a_m_valid, a_m_ready, a_perr, a_ferr, a_ovf;
    logic [2:0] a_rx_count;

    logic [15:0] b_s_data, b_m_data;
    logic        b_s_valid, b_s_ready, b_ctrl_o, b_par_o, b_m_valid, b_m_ready, b_clear;
    logic [3:0]  b_data_o;
    logic [2:0]  b_rx_count;
    logic        b_perr, b_ferr, b_ovf;

    assign a_data_i = a_data_o;
    assign a_ctrl_i = a_ctrl_o & ~kill;
    assign a_par_i  = a_par_o ^ flip;

    interfpga_link dut_a (
        .clk(clk), .reset(reset),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .data_o(a_data_o), .ctrl_o(a_ctrl_o), .par_o(a_par_o),
        .data_i(a_data_i), .ctrl_i(a_ctrl_i), .par_i(a_par_i),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .rx_count(a_rx_count), .clear_err(clear_err),
        .parity_err(a_perr), .frame_err(a_ferr), .overflow(a_ovf)
    );

    interfpga_link #(.DATA_W(16), .LANE_W(4), .HOLD(3), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .data_o(b_data_o), .ctrl_o(b_ctrl_o), .par_o(b_par_o),
        .data_i(b_data_o), .ctrl_i(b_ctrl_o), .par_i(b_par_o),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .rx_count(b_rx_count), .clear_err(b_clear),
        .parity_err(b_perr), .frame_err(b_ferr), .overflow(b_ovf)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no response within the cycle bound", nm);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a;
        for (int n = 0; !a_s_ready; n++) begin
            if (n == 10) begin
                tmo("a_s_ready");
                break;
            end
            tick();
        end
    endtask

    task automatic send_a(input logic [7:0] w, input logic fl, output logic p);
        a_s_data  = w;
        a_s_valid = 1'b1;
        flip      = fl;
        wait_ready_a();
        tick();
        a_s_valid = 1'b0;
        p = a_par_o;
        for (int n = 0; a_ctrl_o; n++) begin
            if (n == 20) begin
                tmo("a_frame_end");
                break;
            end
            tick();
        end
        flip = 1'b0;
    endtask

    task automatic pop_a;
        a_m_ready = 1'b1;
        tick();
        a_m_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] word;
        logic       flip;
        logic       exp_par;
        logic       exp_perr;
        logic [2:0] exp_cnt;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs [8];
    logic [3:0] exp_b [4];
    logic [3:0] nib_b [4];
    logic [7:0] exp_q [4];
    logic       p;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 3'd1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b0, 3'd1, 8'h01};
        vecs[3] = '{8'h77, 1'b0, 1'b0, 1'b0, 3'd1, 8'h77};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 3'd1, 8'hFF};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 3'd1, 8'h80};
        vecs[6] = '{8'h5B, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00};
        exp_b = '{4'h5, 4'h5, 4'hA, 4'hA};
        nib_b = '{4'hF, 4'hE, 4'hE, 4'hB};
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h15};

        reset = 1'b1;
        clear_err = 1'b0; kill = 1'b0; flip = 1'b0;
        a_s_data = '0; a_s_valid = 1'b0; a_m_ready = 1'b0;
        b_s_data = '0; b_s_valid = 1'b0; b_m_ready = 1'b0; b_clear = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", 32'(a_s_ready), 0);
        chk("rst_ctrl_o", 32'(a_ctrl_o), 0);
        chk("rst_data_o", 32'(a_data_o), 0);
        chk("rst_par_o", 32'(a_par_o), 0);
        chk("rst_m_valid", 32'(a_m_valid), 0);
        chk("rst_m_data", 32'(a_m_data), 0);
        chk("rst_rx_count", 32'(a_rx_count), 0);
        chk("rst_flags", 32'({a_perr, a_ferr, a_ovf}), 0);
        reset = 1'b0;
        #1;
        chk("s_ready_after_reset", 32'(a_s_ready), 1);

        // single 0xA5 frame, beat by beat
        a_s_data  = 8'hA5;
        a_s_valid = 1'b1;
        wait_ready_a();
        tick();
        a_s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("a5_ctrl_o", 32'(a_ctrl_o), 1);
            chk("a5_data_o", 32'(a_data_o), 32'(exp_b[k]));
            chk("a5_par_o", 32'(a_par_o), 0);
            tick();
        end
        chk("a5_gap_ctrl_o", 32'(a_ctrl_o), 0);
        chk("a5_gap_data_o", 32'(a_data_o), 0);
        chk("a5_gap_s_ready", 32'(a_s_ready), 0);
        chk("a5_m_valid", 32'(a_m_valid), 1);
        chk("a5_m_data", 32'(a_m_data), 32'h A5);
        tick();
        chk("a5_idle_s_ready", 32'(a_s_ready), 1);
        pop_a();
        chk("a5_pop_count", 32'(a_rx_count), 0);

        for (int i = 0; i < 8; i++) begin
            send_a(vecs[i].word, vecs[i].flip, p);
            chk("vec_par_o", 32'(p), 32'(vecs[i].exp_par));
            chk("vec_parity_err", 32'(a_perr), 32'(vecs[i].exp_perr));
            chk("vec_rx_count", 32'(a_rx_count), 32'(vecs[i].exp_cnt));
            chk("vec_m_data", 32'(a_m_data), 32'(vecs[i].exp_data));
            pop_a();
            clear_err = 1'b1;
            tick();
            clear_err = 1'b0;
            chk("vec_clear_perr", 32'(a_perr), 0);
            chk("vec_drained", 32'(a_rx_count), 0);
        end

        // back-to-back 0x01, 0x02 with s_valid held
        a_s_data  = 8'h01;
        a_s_valid = 1'b1;
        wait_ready_a();
        tick();
        a_s_data = 8'h02;
        repeat (4) tick();
        chk("b2b_gap_ctrl_o", 32'(a_ctrl_o), 0);
        chk("b2b_gap_s_ready", 32'(a_s_ready), 0);
        tick();
        chk("b2b_idle_s_ready", 32'(a_s_ready), 1);
        tick();
        a_s_valid = 1'b0;
        chk("b2b_second_ctrl_o", 32'(a_ctrl_o), 1);
        chk("b2b_second_beat0", 32'(a_data_o), 32'h2);
        for (int n = 0; a_ctrl_o; n++) begin
            if (n == 20) begin
                tmo("b2b_frame_end");
                break;
            end
            tick();
        end
        chk("b2b_count", 32'(a_rx_count), 2);
        chk("b2b_first", 32'(a_m_data), 32'h01);
        pop_a();
        chk("b2b_second", 32'(a_m_data), 32'h02);
        pop_a();
        chk("b2b_drained", 32'(a_rx_count), 0);

        // abort with clear_err in the same cycle as the new frame error
        send_a(8'h3C, 1'b1, p);
        chk("abort_pre_perr", 32'(a_perr), 1);
        a_s_data  = 8'h99;
        a_s_valid = 1'b1;
        wait_ready_a();
        tick();
        a_s_valid = 1'b0;
        tick();
        tick();
        kill = 1'b1;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("abort_frame_err", 32'(a_ferr), 1);
        chk("abort_perr_cleared", 32'(a_perr), 0);
        chk("abort_no_push", 32'(a_rx_count), 0);
        for (int n = 0; a_ctrl_o; n++) begin
            if (n == 20) begin
                tmo("abort_frame_end");
                break;
            end
            tick();
        end
        kill = 1'b0;
        send_a(8'h77, 1'b0, p);
        chk("after_abort_m_valid", 32'(a_m_valid), 1);
        chk("after_abort_m_data", 32'(a_m_data), 32'h77);
        chk("after_abort_ferr_sticky", 32'(a_ferr), 1);
        pop_a();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ferr_cleared", 32'(a_ferr), 0);

        // overflow with m_ready low
        for (int i = 0; i < 5; i++) begin
            send_a(8'h10 + 8'(i), 1'b0, p);
            chk("ovf_count", 32'(a_rx_count), (i < 4) ? i + 1 : 4);
        end
        chk("ovf_flag", 32'(a_ovf), 1);
        chk("ovf_head", 32'(a_m_data), 32'h10);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("ovf_cleared", 32'(a_ovf), 0);

        // push into a full FIFO with a pop on the same edge
        a_s_data  = 8'h15;
        a_s_valid = 1'b1;
        wait_ready_a();
        tick();
        a_s_valid = 1'b0;
        tick();
        tick();
        tick();
        a_m_ready = 1'b1;
        tick();
        a_m_ready = 1'b0;
        chk("full_pushpop_count", 32'(a_rx_count), 4);
        chk("full_pushpop_no_ovf", 32'(a_ovf), 0);
        for (int i = 0; i < 4; i++) begin
            chk("full_drain_order", 32'(a_m_data), 32'(exp_q[i]));
            pop_a();
        end
        chk("full_drained", 32'(a_rx_count), 0);

        // reset in the middle of a frame
        a_s_data  = 8'h42;
        a_s_valid = 1'b1;
        wait_ready_a();
        tick();
        a_s_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_ctrl_o", 32'(a_ctrl_o), 0);
        chk("midrst_s_ready", 32'(a_s_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_s_ready_after", 32'(a_s_ready), 1);
        repeat (4) tick();
        chk("midrst_no_push", 32'(a_rx_count), 0);
        chk("midrst_flags", 32'({a_perr, a_ferr, a_ovf}), 0);
        send_a(8'h5A, 1'b0, p);
        chk("midrst_next_frame", 32'(a_m_data), 32'h5A);

        // 16-bit, HOLD=3 instance
        b_s_data  = 16'hBEEF;
        b_s_valid = 1'b1;
        for (int n = 0; !b_s_ready; n++) begin
            if (n == 10) begin
                tmo("b_s_ready");
                break;
            end
            tick();
        end
        tick();
        b_s_valid = 1'b0;
        chk("beef_par_o", 32'(b_par_o), 1);
        for (int k = 0; k < 12; k++) begin
            chk("beef_ctrl_o", 32'(b_ctrl_o), 1);
            chk("beef_data_o", 32'(b_data_o), 32'(nib_b[k / 3]));
            tick();
        end
        chk("beef_ctrl_end", 32'(b_ctrl_o), 0);
        chk("beef_m_valid", 32'(b_m_valid), 1);
        chk("beef_m_data", 32'(b_m_data), 32'hBEEF);
        chk("beef_flags", 32'({b_perr, b_ferr, b_ovf}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/interfpga_link.md
INTERFPGA_LINK -- requirements
Module: interfpga_link

Interface
- REQ-001 Parameter DATA_W, default 8: payload word width; SHALL be a multiple of LANE_W.
- REQ-002 Parameter LANE_W, default 4: data lanes per direction.
- REQ-003 Parameter HOLD, default 2: cycles each beat is held on the lanes; SHALL be at least 1.
- REQ-004 Parameter DEPTH, default 4: RX FIFO entries; SHALL be a power of two and at least 2; BEATS = DATA_W/LANE_W.
- REQ-005 clk  in  1  clock; all state updates on the rising edge.
- REQ-006 reset  in  1  reset, synchronous, active-high.
- REQ-007 s_data  in  DATA_W  TX word; s_valid  in  1  TX word offered; s_ready  out  1  TX can accept.
- REQ-008 data_o  out  LANE_W  TX lanes; ctrl_o  out  1  TX frame active; par_o  out  1  TX even parity of the frame word.
- REQ-009 data_i  in  LANE_W  RX lanes; ctrl_i  in  1  RX frame active; par_i  in  1  RX parity.
- REQ-010 m_data  out  DATA_W  FIFO head; m_valid  out  1  FIFO not empty; m_ready  in  1  consumer pops.
- REQ-011 rx_count  out  clog2(DEPTH)+1  FIFO occupancy; clear_err  in  1  clears sticky flags.
- REQ-012 parity_err, frame_err, overflow  out  1 each  sticky error flags.

Function
- REQ-013 TX SHALL use states IDLE, SEND, GAP; s_ready SHALL be 1 only in IDLE.
- REQ-014 On s_valid&&s_ready at cycle N, TX SHALL latch s_data and enter SEND; ctrl_o=1 for cycles N+1..N+BEATS*HOLD.
- REQ-015 During SEND, beat k (k=0..BEATS-1) SHALL drive data_o=word[k*LANE_W +: LANE_W], LSB beat first, for HOLD consecutive cycles.
- REQ-016 par_o SHALL equal XOR of all latched word bits for the whole frame and 0 outside frames.
- REQ-017 After the last beat TX SHALL spend exactly one GAP cycle with ctrl_o=0, then return to IDLE; data_o SHALL be 0 whenever ctrl_o=0.
- REQ-018 RX SHALL use states IDLE, RECV, WAIT_LOW; IDLE->RECV when ctrl_i=1, that cycle being beat 0 sub-cycle 0.
- REQ-019 RX SHALL sample data_i and par_i on sub-cycle HOLD-1 of each beat into bits [k*LANE_W +: LANE_W].
- REQ-020 If ctrl_i=0 during any RECV cycle before the frame's BEATS*HOLD cycles complete, RX SHALL discard the frame, set frame_err and return to IDLE.
- REQ-021 On the final RECV cycle RX SHALL compute the word and parity; the word SHALL be pushed the following cycle (cycle after frame end), or discarded with parity_err set on mismatch against the last-sampled par_i.
- REQ-022 After a complete frame, RX SHALL go to IDLE if ctrl_i=0 in the next cycle, else to WAIT_LOW until ctrl_i=0; no frame starts from WAIT_LOW.
- REQ-023 FIFO push when full and no same-cycle pop SHALL drop the word and set overflow; push and pop in the same cycle when full SHALL both succeed.
- REQ-024 Pop when m_valid&&m_ready; m_data SHALL be the oldest entry; pointers wrap modulo DEPTH; rx_count SHALL track occupancy exactly, 0..DEPTH.
- REQ-025 clear_err SHALL clear all sticky flags next cycle; a new error in the same cycle SHALL win and leave its flag set.

Reset
- REQ-026 While reset=1: TX and RX in IDLE, FIFO empty, s_ready=0, ctrl_o=0, data_o=0, par_o=0, m_valid=0, m_data=0, rx_count=0, all error flags 0.
- REQ-027 First cycle after reset deasserts s_ready SHALL be 1; reset mid-frame SHALL abort TX and RX frames without any FIFO push or flag change.

Verification
- REQ-028 Loopback, defaults, send 0xA5 -> ctrl_o high 4 cycles, data_o 5,5,A,A, par_o=0; m_data=0xA5 and m_valid=1 one cycle after frame end.
- REQ-029 Back-to-back s_valid with 0x01,0x02 -> second frame starts after one GAP cycle; FIFO yields 0x01 then 0x02.
- REQ-030 Inject par_i inverted on 0x3C -> no push, parity_err=1, rx_count unchanged; clear_err -> parity_err=0.
- REQ-031 Drop ctrl_i after 2 of 4 cycles -> frame_err=1, no push; next clean frame 0x77 received normally.
- REQ-032 m_ready=0, send 5 words with DEPTH=4 -> rx_count=4, overflow=1, FIFO holds first 4 in order.
- REQ-033 DATA_W=16, LANE_W=4, HOLD=3, send 0xBEEF -> ctrl_o high 12 cycles, beats F,E,E,B, received 0xBEEF.
